// File: rtl/coin_input_conditioner_pkg.sv
// Shared types and constants for the coin front end and the credit logic downstream.
// Pending-bit layout and the Q > D > N > REJ arbitration live here so both sides agree.
package coin_pkg;

    typedef enum logic [2:0] {
        COIN_NONE = 3'd0,
        COIN_N    = 3'd1,
        COIN_D    = 3'd2,
        COIN_Q    = 3'd3,
        COIN_REJ  = 3'd4
    } coin_e;

    localparam int NICKEL_VAL          = 32'd5;
    localparam int DIME_VAL            = 32'd10;
    localparam int QUARTER_VAL         = 32'd25;
    localparam int DEBOUNCE_CYCLES_DEF = 32'd4;

    // Pending vector bit positions; channel index equals pending index for N/D/Q.
    localparam int PEND_N   = 32'd0;
    localparam int PEND_D   = 32'd1;
    localparam int PEND_Q   = 32'd2;
    localparam int PEND_REJ = 32'd3;
    localparam int PEND_W   = 32'd4;

    function automatic coin_e pick_coin(input logic [PEND_W-1:0] pend);
        coin_e c;
        if (pend[PEND_Q]) begin
            c = COIN_Q;
        end else if (pend[PEND_D]) begin
            c = COIN_D;
        end else if (pend[PEND_N]) begin
            c = COIN_N;
        end else if (pend[PEND_REJ]) begin
            c = COIN_REJ;
        end else begin
            c = COIN_NONE;
        end
        return c;
    endfunction

    function automatic logic [PEND_W-1:0] coin_mask(input coin_e c);
        logic [PEND_W-1:0] m;
        case (c)
            COIN_N:   m = 4'b0001;
            COIN_D:   m = 4'b0010;
            COIN_Q:   m = 4'b0100;
            COIN_REJ: m = 4'b1000;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce_ch.sv
// One sensor channel: two-flop synchronizer, stability counter and debounced level.
// rise is combinational and marks the very edge on which the level will go 0->1.
module coin_debounce_ch
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 4
) (
    input  logic CLKb,
    input  logic RSTb,
    input  logic raw,
    output logic s,
    output logic rise
);

    logic             sync1_r;
    logic             sync2_r;
    logic             s_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             reach_s;

    // Detect disagreement and the sample that completes the stability run.
    always_comb begin
        differ_s = sync2_r ^ s_r;
        reach_s  = differ_s && (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));
    end

    assign s    = s_r;
    assign rise = reach_s & ~s_r;

    // Synchronizer, counter and debounced level update.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            s_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (!differ_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (reach_s) begin
                s_r   <= ~s_r;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin front end: three debounced sensor channels, EN steering into pending bits,
// and a priority arbiter that emits one registered credit/reject pulse per cycle.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 4
) (
    input  logic CLKb,
    input  logic RSTb,
    input  logic NICKEL_RAW,
    input  logic DIME_RAW,
    input  logic QUARTER_RAW,
    input  logic EN,
    output logic N,
    output logic D,
    output logic Q,
    output logic REJ,
    output logic BUSY
);

    logic [2:0]        raw_s;
    logic [2:0]        rise_s;
    logic [2:0]        level_unused_s;
    logic [PEND_W-1:0] pend_r;
    logic [PEND_W-1:0] set_s;
    logic [PEND_W-1:0] grant_s;
    coin_e             pick_s;
    logic              n_r;
    logic              d_r;
    logic              q_r;
    logic              rej_r;

    assign raw_s = {QUARTER_RAW, DIME_RAW, NICKEL_RAW};

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        coin_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .CLKb (CLKb),
            .RSTb (RSTb),
            .raw  (raw_s[ch]),
            .s    (level_unused_s[ch]),
            .rise (rise_s[ch])
        );
    end

    // Coins seen while disabled all fold into the single reject bit.
    always_comb begin
        set_s = 4'b0000;
        if (EN) begin
            set_s[2:0] = rise_s;
        end else begin
            set_s[PEND_REJ] = |rise_s;
        end
        pick_s  = pick_coin(pend_r);
        grant_s = coin_mask(pick_s);
    end

    // Pending bookkeeping and output register; a re-set on the grant edge wins.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            pend_r <= 4'b0000;
            n_r    <= 1'b0;
            d_r    <= 1'b0;
            q_r    <= 1'b0;
            rej_r  <= 1'b0;
        end else begin
            pend_r <= (pend_r & ~grant_s) | set_s;
            n_r    <= (pick_s == COIN_N);
            d_r    <= (pick_s == COIN_D);
            q_r    <= (pick_s == COIN_Q);
            rej_r  <= (pick_s == COIN_REJ);
        end
    end

    assign N    = n_r;
    assign D    = d_r;
    assign Q    = q_r;
    assign REJ  = rej_r;
    assign BUSY = |pend_r;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses (kind + negedge index), a monitor
// process compares every pulse the DUT presents against the queue head.
module tb_coin_input_conditioner;
    import coin_pkg::*;

    typedef struct {
        coin_e coin;
        int    cyc;
    } exp_t;

    logic CLKb, RSTb, NICKEL_RAW, DIME_RAW, QUARTER_RAW, EN;
    logic N, D, Q, REJ, BUSY;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    coin_input_conditioner dut (
        .CLKb        (CLKb),
        .RSTb        (RSTb),
        .NICKEL_RAW  (NICKEL_RAW),
        .DIME_RAW    (DIME_RAW),
        .QUARTER_RAW (QUARTER_RAW),
        .EN          (EN),
        .N           (N),
        .D           (D),
        .Q           (Q),
        .REJ         (REJ),
        .BUSY        (BUSY)
    );

    initial begin
        CLKb = 1'b1;
        forever #5 CLKb = ~CLKb;
    end

    always @(negedge CLKb) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLKb);
    endtask

    task automatic expect_pulse(input coin_e c, input int at);
        exp_t e;
        e.coin = c;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: sample mid-cycle, one comparison per presented pulse.
    always @(posedge CLKb) begin
        int    nhi;
        coin_e obs;
        exp_t  e;
        if (RSTb === 1'b1) begin
            nhi = int'(N) + int'(D) + int'(Q) + int'(REJ);
            if (nhi != 0) begin
                chk(nhi == 1, "onehot", nhi, 1);
                if (Q)        obs = COIN_Q;
                else if (D)   obs = COIN_D;
                else if (N)   obs = COIN_N;
                else          obs = COIN_REJ;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_pulse", int'(obs), int'(COIN_NONE));
                end else begin
                    e = exp_q.pop_front();
                    chk(obs == e.coin, "pulse_kind", int'(obs), int'(e.coin));
                    chk(cyc == e.cyc, "pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        RSTb = 1'b0; NICKEL_RAW = 1'b0; DIME_RAW = 1'b0; QUARTER_RAW = 1'b0; EN = 1'b1;
        tick(3);
        chk({N, D, Q, REJ, BUSY} == 5'b00000, "reset_outputs", int'({N, D, Q, REJ, BUSY}), 0);
        RSTb = 1'b1;
        tick(3);

        // Clean quarter: pulse on edges c+7..c+8, BUSY only after edge c+6.
        c = cyc; QUARTER_RAW = 1'b1; expect_pulse(COIN_Q, c + 7);
        tick(5); chk(BUSY == 1'b0, "busy_q_before", int'(BUSY), 0);
        tick(1); chk(BUSY == 1'b1, "busy_q_pending", int'(BUSY), 1);
        tick(1); chk(BUSY == 1'b0, "busy_q_drained", int'(BUSY), 0);
        tick(3); QUARTER_RAW = 1'b0; tick(12);

        // Bouncing dime: counted once, latency measured from the last transition.
        DIME_RAW = 1'b1; tick(1); DIME_RAW = 1'b0; tick(1);
        DIME_RAW = 1'b1; tick(1); DIME_RAW = 1'b0; tick(1);
        c = cyc; DIME_RAW = 1'b1; expect_pulse(COIN_D, c + 7);
        tick(12); DIME_RAW = 1'b0; tick(12);

        // Three-sample glitch must be filtered out.
        DIME_RAW = 1'b1; tick(3); DIME_RAW = 1'b0; tick(14);

        // Simultaneous coins drain Q, D, N on consecutive cycles.
        c = cyc; NICKEL_RAW = 1'b1; DIME_RAW = 1'b1; QUARTER_RAW = 1'b1;
        expect_pulse(COIN_Q, c + 7); expect_pulse(COIN_D, c + 8); expect_pulse(COIN_N, c + 9);
        tick(6); chk(BUSY == 1'b1, "busy_sim_first", int'(BUSY), 1);
        tick(2); chk(BUSY == 1'b1, "busy_sim_last", int'(BUSY), 1);
        tick(1); chk(BUSY == 1'b0, "busy_sim_done", int'(BUSY), 0);
        tick(3); NICKEL_RAW = 1'b0; DIME_RAW = 1'b0; QUARTER_RAW = 1'b0; tick(12);

        // Disabled: single nickel, then nickel+dime merged, each one REJ.
        EN = 1'b0; tick(1);
        c = cyc; NICKEL_RAW = 1'b1; expect_pulse(COIN_REJ, c + 7);
        tick(12); NICKEL_RAW = 1'b0; tick(12);
        c = cyc; NICKEL_RAW = 1'b1; DIME_RAW = 1'b1; expect_pulse(COIN_REJ, c + 7);
        tick(12); NICKEL_RAW = 1'b0; DIME_RAW = 1'b0; tick(12);
        EN = 1'b1; tick(1);

        // EN drops right before the dime's debounce edge c+6 -> reject.
        c = cyc; DIME_RAW = 1'b1; expect_pulse(COIN_REJ, c + 7);
        tick(5); EN = 1'b0; tick(1); EN = 1'b1;
        tick(6); DIME_RAW = 1'b0; tick(12);

        // Reset after the first drained pulse discards the rest; held quarter recounts.
        c = cyc; NICKEL_RAW = 1'b1; DIME_RAW = 1'b1; QUARTER_RAW = 1'b1;
        expect_pulse(COIN_Q, c + 7);
        tick(7); #1; RSTb = 1'b0; #1;
        chk({N, D, Q, REJ, BUSY} == 5'b00000, "midreset_outputs", int'({N, D, Q, REJ, BUSY}), 0);
        tick(1); NICKEL_RAW = 1'b0; DIME_RAW = 1'b0; tick(2);
        c = cyc; RSTb = 1'b1; expect_pulse(COIN_Q, c + 7);
        tick(20); QUARTER_RAW = 1'b0; tick(12);

        chk(exp_q.size() == 0, "missing_pulses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage of the vending machine that conditions the raw coin-sensor lines and feeds the JK-flip-flop credit/state logic directly downstream.
- Each sensor line is synchronized, debounced and edge-detected.
- Results are emitted as mutually exclusive single-cycle credit pulses on the same negative-edge clock the state logic uses.
- Coins sensed while acceptance is disabled become a reject pulse that drives the coin-return path instead of a credit.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to change a channel's debounced state. Legal range 2..15.
- CNT_W, default 4: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLKb  input  1  clock; all state updates on the negative edge.
- RSTb  input  1  reset, asynchronous, active-low.
- NICKEL_RAW  input  1  raw nickel sensor, asynchronous to CLKb, may bounce.
- DIME_RAW  input  1  raw dime sensor, same properties.
- QUARTER_RAW  input  1  raw quarter sensor, same properties.
- EN  input  1  coin acceptance enable, synchronous to CLKb.
- N  output  1  nickel credit pulse, one cycle.
- D  output  1  dime credit pulse, one cycle.
- Q  output  1  quarter credit pulse, one cycle.
- REJ  output  1  reject pulse (coin sensed while disabled), one cycle.
- BUSY  output  1  high while any pending bit is set.

Behaviour:
- Reset (RSTb=0, async, immediate):
  - Clears synchronizers, debounced states, counters and pending bits.
  - N, D, Q, REJ and BUSY are 0 while reset is held.
- Synchronizer: two flops per channel.
- Debounce, per channel:
  - Debounced state s and counter cnt.
  - On each edge where the sync output equals s, cnt clears to 0.
  - Otherwise cnt increments; on the edge where cnt would reach DEBOUNCE_CYCLES, s toggles and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never toggles s.
- Rising-edge detect, on the edge where s goes 0->1:
  - EN=1: set that channel's pending bit.
  - EN=0: set the reject-pending bit instead.
  - EN is sampled on that same edge. Falling transitions of s produce nothing.
- Arbiter/output register, every edge:
  - If any pending bit is set, exactly one output is asserted for the following cycle and that pending bit is cleared on the same edge.
  - Priority order: Q > D > N > REJ.
  - With nothing pending, all outputs are 0.
  - N, D, Q and REJ are registered and never two at once.
- Simultaneous events:
  - Multiple channels debounce on the same edge: all pending bits are set, then drained one per cycle in priority order over consecutive cycles.
  - A pending bit being issued on the same edge it is set again: it stays set. Cannot occur for DEBOUNCE_CYCLES>=2; the spec defines it anyway.
  - Reject-pending already set when another rejected coin arrives: the two merge into one REJ pulse. This is acceptable because the return path is coin-agnostic.
- Latency, first sampling edge of a clean raw rise = edge 1:
  - s rises at edge 2+DEBOUNCE_CYCLES.
  - The pulse is high from edge 3+DEBOUNCE_CYCLES to edge 4+DEBOUNCE_CYCLES (edges 7..8 at default), if no higher-priority bit is pending.
- BUSY is combinational OR of the pending bits.
- Reset mid-operation:
  - In-flight pending coins are discarded.
  - A raw line held high through reset release is counted once after the normal latency, since s resets to 0.

Decomposition:
- Package coin_pkg holds:
  - enum coin_e {COIN_NONE, COIN_N, COIN_D, COIN_Q, COIN_REJ};
  - constants NICKEL_VAL=5, DIME_VAL=10, QUARTER_VAL=25 (used downstream);
  - default DEBOUNCE_CYCLES.
- Sub-module coin_debounce_ch, instantiated 3x, contains the 2-flop synchronizer, counter and s register. It outputs s and a one-cycle rise strobe.
- Top level holds the pending bits, EN steering and the priority arbiter/output register.

Test Plan:
- Clean quarter: QUARTER_RAW 0->1 held 10 cycles, EN=1, default params -> Q high exactly one cycle, edge 7..8; N=D=REJ=0; BUSY high for one cycle just before.
- Bounce: DIME_RAW toggles 1,0,1,0 each cycle, then held 1 -> exactly one D pulse, 3+DEBOUNCE_CYCLES edges after the last transition; a 3-cycle-only high glitch -> no pulse.
- Simultaneous: all three raw lines rise on the same cycle, EN=1 -> Q, D, N pulses on three consecutive cycles in that order; BUSY high for 3 cycles.
- Disabled: EN=0 when the nickel debounces -> REJ pulse one cycle, N stays 0. Nickel and dime together with EN=0 -> single REJ pulse.
- Mixed EN: EN toggled 1->0 on the edge the dime debounces -> REJ pulse, not D.
- Reset mid-drain: three coins pending, RSTb low after the first Q pulse -> all outputs and BUSY 0 immediately, no D/N after release. A raw line held high across release -> one pulse at nominal latency.
